regfile_bypass: RTL and testbench
=================================

# regfile_bypass

Parametrised register file for the pipelined MIPS core. It provides NRD registered read ports and resolves operands from the EX, MEM and WB result buses before falling back to the storage array. It tracks in-flight loads with a per-register busy scoreboard and raises a load-use stall. It sits between decode and the ALU operand registers, and replaces the ad-hoc register array and forwarding logic in the core top.

## Interface

Parameters:
- DATA_W, 32, register width in bits
- NREGS, 32, number of architectural registers; register 0 is hard-wired to zero
- NRD, 2, number of read ports
- AW, $clog2(NREGS), register address width (derived; do not override)

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_en  in  NRD  per-port read request
- rd_addr  in  NRD*AW  per-port read address; port i occupies bits [i*AW +: AW]
- rd_data  out  NRD*DATA_W  registered, bypass-resolved read data
- stall  out  1  load-use hazard on any enabled read port
- ex_wr_en, ex_wr_addr (AW), ex_wr_data (DATA_W)  in  EX-stage ALU result bus
- mem_wr_en, mem_wr_addr (AW), mem_wr_data (DATA_W)  in  MEM-stage result bus
- wb_wr_en, wb_wr_addr (AW), wb_wr_data (DATA_W), wb_is_load (1)  in  write-back commit bus
- ld_issue  in  1  a load is dispatched this cycle
- ld_addr  in  AW  destination register of the issued load
- flush  in  1  squash all in-flight loads

## Operation

- **Array write:** written only from the WB bus, when wb_wr_en=1 and wb_wr_addr≠0. Writes to register 0 are ignored.
- **Operand resolution per port, priority high→low:**
  - register 0 → 0
  - EX match (ex_wr_en and address equal)
  - MEM match
  - WB match
  - array
- **Busy scoreboard:** one bit per register; bit 0 is constant 0.
  - Set on ld_issue, when flush=0 and ld_addr≠0.
  - Cleared on a WB write with wb_is_load=1 to that address.
  - If set and clear hit the same address in the same cycle, set wins.
- **stall:** asserted when any port i has rd_en[i]=1, busy[rd_addr[i]]=1, and that register is not being cleared by this cycle's WB load write. A WB load write in the same cycle resolves the hazard through the WB bypass.
- **rd_data update:** updates only for ports with rd_en=1 while stall=0. Otherwise each port holds its previous value.
- **flush:** clears every busy bit at the next edge and suppresses a coincident ld_issue. Array contents and rd_data are unaffected.
- **Busy visibility:** a read in the same cycle as ld_issue to the same register sees busy=0. Only bits set in earlier cycles are visible.

## Timing

- Read latency: 1 cycle. Data resolved in cycle N appears on rd_data after edge N.
- Bypass paths are combinational into the rd_data register. A WB write in cycle N is readable in cycle N through the bypass and from the array from N+1.
- stall is combinational from rd_en, rd_addr, busy and the WB inputs, and is valid in the same cycle.
- Busy bit set at edge N is visible to reads in cycle N+1.
- Reset (asynchronous, immediate):
  - array = 0, busy = 0, rd_data = 0
  - stall = 0 while reset_n=0
  - statistics counters = 0
- Reset asserted mid-load discards all busy state. No write-back is required afterwards.

## Configuration

- **REGFILE_BYPASS_STATS_EN defined:** adds two outputs:
  - stall_cnt (32 bits): increments each cycle stall=1.
  - byp_cnt (32 bits): increments each cycle at least one port with rd_en=1 and no stall takes data from EX, MEM or WB.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- **Not defined:** both ports and counters are absent. Behaviour is otherwise identical.

## Structure

- **Package regfile_pkg:**
  - byp_src_t enum: SRC_ZERO, SRC_EX, SRC_MEM, SRC_WB, SRC_ARRAY
  - localparam REG_ZERO = 0
- **Sub-module regfile_bypass_mux:** one instance per read port. It takes the address and the three result buses plus the array word, and returns the resolved data and its byp_src_t.
- **Top level** holds the array, busy scoreboard, stall logic, rd_data registers and the optional counters.

## Test plan

- **Reset:** hold reset_n=0 for 3 cycles, release, read r5 on port 0 → rd_data port 0 = 0, stall=0.
- **WB bypass:** wb_wr_en, r3=0x00001234 in cycle N with read r3 in N → 0x00001234 after edge N. Read r3 in N+1 with no buses active → 0x00001234 from the array.
- **Priority:** in one cycle, EX r4=1, MEM r4=2, WB r4=3; port 0 and port 1 both read r4 → both return 1. Next cycle, read r4 with no buses active → 3.
- **Register 0:** WB r0=0xFFFFFFFF and EX r0=5, read r0 → 0. Subsequent read of r0 → 0.
- **Load-use:**
  - ld_issue r7 in cycle N.
  - Read r7 in N+1 → stall=1, rd_data holds its old value.
  - In N+2, WB load r7=0xAB with the read still asserted → stall=0, rd_data=0xAB after edge N+2.
  - Read r7 in N+3 → no stall.
- **Flush:** ld_issue r9, then flush in the next cycle, then read r9 → stall=0, returns the array value. ld_issue coincident with flush leaves busy clear.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the bypassing register file: operand source encoding and
// the hard-wired zero register index.
package regfile_pkg;

  typedef enum logic [2:0] {
    SRC_ZERO,
    SRC_EX,
    SRC_MEM,
    SRC_WB,
    SRC_ARRAY
  } byp_src_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-port operand resolver: register 0, then EX, MEM, WB result buses, then the
// storage array word. Purely combinational.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic [AW-1:0]     rdAddr,
  input  logic              exWrEn,
  input  logic [AW-1:0]     exWrAddr,
  input  logic [DATA_W-1:0] exWrData,
  input  logic              memWrEn,
  input  logic [AW-1:0]     memWrAddr,
  input  logic [DATA_W-1:0] memWrData,
  input  logic              wbWrEn,
  input  logic [AW-1:0]     wbWrAddr,
  input  logic [DATA_W-1:0] wbWrData,
  input  logic [DATA_W-1:0] arrayWord,
  output logic [DATA_W-1:0] data,
  output byp_src_t          src
);

  always_comb begin
    data = arrayWord;
    src  = SRC_ARRAY;
    if (rdAddr == AW'(REG_ZERO)) begin
      data = '0;
      src  = SRC_ZERO;
    end else if (exWrEn && exWrAddr == rdAddr) begin
      data = exWrData;
      src  = SRC_EX;
    end else if (memWrEn && memWrAddr == rdAddr) begin
      data = memWrData;
      src  = SRC_MEM;
    end else if (wbWrEn && wbWrAddr == rdAddr) begin
      data = wbWrData;
      src  = SRC_WB;
    end
  end

endmodule

// File: rtl/regfile_bypass.sv
// Register file with EX/MEM/WB bypass, load busy scoreboard and load-use stall.
// Optional stall/bypass statistics counters under REGFILE_BYPASS_STATS_EN.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic                  stall,
  input  logic                  ex_wr_en,
  input  logic [AW-1:0]         ex_wr_addr,
  input  logic [DATA_W-1:0]     ex_wr_data,
  input  logic                  mem_wr_en,
  input  logic [AW-1:0]         mem_wr_addr,
  input  logic [DATA_W-1:0]     mem_wr_data,
  input  logic                  wb_wr_en,
  input  logic [AW-1:0]         wb_wr_addr,
  input  logic [DATA_W-1:0]     wb_wr_data,
  input  logic                  wb_is_load,
  input  logic                  ld_issue,
  input  logic [AW-1:0]         ld_addr,
`ifdef REGFILE_BYPASS_STATS_EN
  output logic [31:0]           stall_cnt,
  output logic [31:0]           byp_cnt,
`endif
  input  logic                  flush
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [DATA_W-1:0] resolved [NRD];
  byp_src_t          srcSel [NRD];
  logic [NRD-1:0]    portStall;
  logic [NRD-1:0]    portByp;
  logic              wbLoadClr;

  assign wbLoadClr = wb_wr_en && wb_is_load;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [AW-1:0] addr;
    assign addr = rd_addr[p*AW +: AW];

    regfile_bypass_mux #(
      .DATA_W (DATA_W),
      .AW     (AW)
    ) u_mux (
      .rdAddr    (addr),
      .exWrEn    (ex_wr_en),
      .exWrAddr  (ex_wr_addr),
      .exWrData  (ex_wr_data),
      .memWrEn   (mem_wr_en),
      .memWrAddr (mem_wr_addr),
      .memWrData (mem_wr_data),
      .wbWrEn    (wb_wr_en),
      .wbWrAddr  (wb_wr_addr),
      .wbWrData  (wb_wr_data),
      .arrayWord (regs[addr]),
      .data      (resolved[p]),
      .src       (srcSel[p])
    );

    // A same-cycle WB load to this register resolves the hazard via the bypass.
    assign portStall[p] = rd_en[p] && busy[addr] &&
                          !(wbLoadClr && wb_wr_addr == addr);
    assign portByp[p]   = rd_en[p] &&
                          (srcSel[p] == SRC_EX || srcSel[p] == SRC_MEM ||
                           srcSel[p] == SRC_WB);
  end

  assign stall = |portStall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_wr_en && wb_wr_addr != AW'(REG_ZERO)) begin
      regs[wb_wr_addr] <= wb_wr_data;
    end
  end

  // Bit 0 is never set, so it stays zero from reset onwards.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (ld_issue && ld_addr == AW'(i))
          busy[i] <= 1'b1;
        else if (wbLoadClr && wb_wr_addr == AW'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (!stall) begin
      for (int unsigned p = 0; p < NRD; p++)
        if (rd_en[p]) rd_data[p*DATA_W +: DATA_W] <= resolved[p];
    end
  end

`ifdef REGFILE_BYPASS_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      byp_cnt   <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (!stall && |portByp && byp_cnt != '1) byp_cnt <= byp_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed self-checking bench for regfile_bypass (default parameters).
module tb_regfile_bypass;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int NRD    = 2;
  localparam int AW     = 5;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [NRD-1:0]        rd_en;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic                  stall;
  logic                  ex_wr_en, mem_wr_en, wb_wr_en, wb_is_load, ld_issue, flush;
  logic [AW-1:0]         ex_wr_addr, mem_wr_addr, wb_wr_addr, ld_addr;
  logic [DATA_W-1:0]     ex_wr_data, mem_wr_data, wb_wr_data;
`ifdef REGFILE_BYPASS_STATS_EN
  logic [31:0]           stall_cnt, byp_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  regfile_bypass #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .NRD    (NRD)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .stall       (stall),
    .ex_wr_en    (ex_wr_en),
    .ex_wr_addr  (ex_wr_addr),
    .ex_wr_data  (ex_wr_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .wb_wr_en    (wb_wr_en),
    .wb_wr_addr  (wb_wr_addr),
    .wb_wr_data  (wb_wr_data),
    .wb_is_load  (wb_is_load),
    .ld_issue    (ld_issue),
    .ld_addr     (ld_addr),
`ifdef REGFILE_BYPASS_STATS_EN
    .stall_cnt   (stall_cnt),
    .byp_cnt     (byp_cnt),
`endif
    .flush       (flush)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] port(input int p);
    return rd_data[p*DATA_W +: DATA_W];
  endfunction

  task automatic idle();
    rd_en = '0; rd_addr = '0;
    ex_wr_en = 0; ex_wr_addr = '0; ex_wr_data = '0;
    mem_wr_en = 0; mem_wr_addr = '0; mem_wr_data = '0;
    wb_wr_en = 0; wb_wr_addr = '0; wb_wr_data = '0; wb_is_load = 0;
    ld_issue = 0; ld_addr = '0; flush = 0;
  endtask

  task automatic rd(input int p, input int addr);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(addr);
  endtask

  task automatic wb(input int addr, input logic [31:0] data, input logic isLoad);
    wb_wr_en = 1; wb_wr_addr = AW'(addr); wb_wr_data = data; wb_is_load = isLoad;
  endtask

  task automatic ldIssue(input int addr);
    ld_issue = 1; ld_addr = AW'(addr);
  endtask

  // Let combinational outputs settle (stall), then cross the edge.
  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  initial begin
    idle();
    reset_n = 0;
    repeat (3) @(posedge clock);
    #1;
    checkEq("reset_rd0", port(0), 32'h0);
    checkEq("reset_rd1", port(1), 32'h0);
    checkEq("reset_stall", {31'd0, stall}, 32'h0);
    reset_n = 1;

    rd(0, 5); settle();
    checkEq("r5_stall", {31'd0, stall}, 32'h0);
    tick();
    checkEq("r5_read", port(0), 32'h0);

    wb(3, 32'h00001234, 0); rd(0, 3); tick();
    checkEq("wb_bypass", port(0), 32'h00001234);
    rd(0, 3); tick();
    checkEq("wb_array", port(0), 32'h00001234);

    ex_wr_en = 1; ex_wr_addr = 4; ex_wr_data = 1;
    mem_wr_en = 1; mem_wr_addr = 4; mem_wr_data = 2;
    wb(4, 3, 0); rd(0, 4); rd(1, 4); tick();
    checkEq("prio_p0", port(0), 32'd1);
    checkEq("prio_p1", port(1), 32'd1);
    rd(0, 4); rd(1, 4); tick();
    checkEq("prio_arr_p0", port(0), 32'd3);
    checkEq("prio_arr_p1", port(1), 32'd3);

    mem_wr_en = 1; mem_wr_addr = 5; mem_wr_data = 32'h22;
    wb(5, 32'h33, 0); rd(1, 5); tick();
    checkEq("mem_over_wb", port(1), 32'h22);

    wb(0, 32'hFFFFFFFF, 0); ex_wr_en = 1; ex_wr_addr = 0; ex_wr_data = 5;
    rd(0, 0); tick();
    checkEq("r0_bypass", port(0), 32'h0);
    rd(0, 0); rd(1, 0); tick();
    checkEq("r0_array_p0", port(0), 32'h0);
    checkEq("r0_array_p1", port(1), 32'h0);

    // Load-use: read of r7 in the issue cycle sees busy=0.
    rd(0, 3); ldIssue(7); rd(1, 7); settle();
    checkEq("ld_same_cycle_stall", {31'd0, stall}, 32'h0);
    tick();
    checkEq("ld_pre_p0", port(0), 32'h00001234);
    rd(0, 7); rd(1, 3); settle();
    checkEq("ld_use_stall", {31'd0, stall}, 32'h1);
    tick();
    checkEq("ld_hold_p0", port(0), 32'h00001234);
    checkEq("ld_hold_p1", port(1), 32'h0);
    rd(0, 7); wb(7, 32'hAB, 1); settle();
    checkEq("ld_wb_stall", {31'd0, stall}, 32'h0);
    tick();
    checkEq("ld_wb_data", port(0), 32'hAB);
    rd(0, 7); settle();
    checkEq("ld_after_stall", {31'd0, stall}, 32'h0);
    tick();
    checkEq("ld_after_data", port(0), 32'hAB);

    // Flush clears busy at the next edge; busy still visible in the flush cycle.
    ldIssue(9); tick();
    flush = 1; rd(1, 9); settle();
    checkEq("flush_cycle_stall", {31'd0, stall}, 32'h1);
    tick();
    rd(0, 9); settle();
    checkEq("flush_after_stall", {31'd0, stall}, 32'h0);
    tick();
    checkEq("flush_read", port(0), 32'h0);
    ldIssue(10); flush = 1; tick();
    rd(0, 10); settle();
    checkEq("flush_ld_suppress", {31'd0, stall}, 32'h0);
    tick();

    // Non-load WB write does not clear busy; set wins over clear.
    ldIssue(11); tick();
    wb(11, 32'h55, 0); rd(0, 11); settle();
    checkEq("nonload_wb_stall", {31'd0, stall}, 32'h1);
    tick();
    rd(0, 11); settle();
    checkEq("nonload_busy_kept", {31'd0, stall}, 32'h1);
    tick();
    ldIssue(12); wb(12, 32'h66, 1); tick();
    rd(0, 12); settle();
    checkEq("set_wins", {31'd0, stall}, 32'h1);
    tick();

    // Asynchronous reset mid-load discards busy state and rd_data.
    ldIssue(13); rd(0, 11); wb(11, 32'h77, 1); tick();
    checkEq("pre_reset_data", port(0), 32'h77);
    reset_n = 0; #1;
    checkEq("async_reset_data", port(0), 32'h0);
    checkEq("async_reset_stall", {31'd0, stall}, 32'h0);
    @(posedge clock); #1; reset_n = 1;
    rd(0, 13); rd(1, 11); settle();
    checkEq("post_reset_stall", {31'd0, stall}, 32'h0);
    tick();
    checkEq("post_reset_array", port(1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
